rewind_walker: RTL and testbench

Multi-cycle ROB rollback sequencer. On a branch mispredict or a full flush, it walks ROB entries from youngest to oldest, up to WIDTH entries per cycle. Each cycle it broadcasts a rewind batch (valid, arc_dst, phy_dst, phy_dst_old, rs_idx) to the map table, free list and RS. It generalises the single-shot rewind bundle with configurable lane count and ROB depth, a flush-all mode, consumer backpressure and a done/new-tail report back to the ROB.

---
 rtl/rewind_walker.sv | 201 ++++++++++++++++++++
 tb/tb_rewind_walker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rewind_walker.sv
// rewind_walker: multi-cycle ROB rollback sequencer.
// Walks ROB entries youngest-to-oldest, up to WIDTH per cycle, and broadcasts
// each batch on registered rw_* lanes to the map table, free list and RS.
// A branch rollback rewinds entries strictly younger than br_idx; flush_all
// rewinds every occupied entry. The new ROB tail is reported alongside done.

module rewind_walker #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int ARC_W = 5,
  parameter int PHY_W = 7,
  parameter int RS_W  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             flush_all,
  input  logic [IDX_W-1:0]                 tail_idx,
  input  logic [IDX_W-1:0]                 br_idx,
  input  logic [IDX_W:0]                   occ,
  output logic [WIDTH-1:0][IDX_W-1:0]      rd_idx,
  input  logic [WIDTH-1:0][ARC_W-1:0]      rd_arc_dst,
  input  logic [WIDTH-1:0][PHY_W-1:0]      rd_phy_dst,
  input  logic [WIDTH-1:0][PHY_W-1:0]      rd_phy_dst_old,
  input  logic [WIDTH-1:0][RS_W-1:0]       rd_rs_idx,
  output logic [WIDTH-1:0]                 rw_valid,
  output logic [WIDTH-1:0][ARC_W-1:0]      rw_arc_dst,
  output logic [WIDTH-1:0][PHY_W-1:0]      rw_phy_dst,
  output logic [WIDTH-1:0][PHY_W-1:0]      rw_phy_dst_old,
  output logic [WIDTH-1:0][RS_W-1:0]       rw_rs_idx,
  input  logic                             rw_ready,
  output logic                             busy,
  output logic                             done,
  output logic [IDX_W-1:0]                 new_tail
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [IDX_W:0]   WIDTH_C = (IDX_W+1)'(WIDTH);
  localparam logic [IDX_W-1:0] ONE_C   = IDX_W'(1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           cursor_q, cursor_d;
  logic [IDX_W:0]             rem_q, rem_d;
  logic [IDX_W-1:0]           nt_q, nt_d;
  logic [WIDTH-1:0]           rw_valid_q, rw_valid_d;
  logic [WIDTH-1:0][ARC_W-1:0] rw_arc_q, rw_arc_d;
  logic [WIDTH-1:0][PHY_W-1:0] rw_phy_q, rw_phy_d;
  logic [WIDTH-1:0][PHY_W-1:0] rw_old_q, rw_old_d;
  logic [WIDTH-1:0][RS_W-1:0]  rw_rs_q, rw_rs_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [IDX_W-1:0]           new_tail_q, new_tail_d;

  logic [IDX_W:0]             take_s;
  logic                       load_s;

  // ROB read addresses: lane k looks at cursor-k, wrapping modulo DEPTH
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      rd_idx[k] = cursor_q - IDX_W'(k);
    end
  end

  // Batch size and output-register load enable (empty register or transfer)
  always_comb begin
    if (rem_q > WIDTH_C) begin
      take_s = WIDTH_C;
    end else begin
      take_s = rem_q;
    end
    load_s = (rw_valid_q == '0) || rw_ready;
  end

  // Next-state and next-output computation for the walk sequencer
  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    rem_d      = rem_q;
    nt_d       = nt_q;
    rw_valid_d = rw_valid_q;
    rw_arc_d   = rw_arc_q;
    rw_phy_d   = rw_phy_q;
    rw_old_d   = rw_old_q;
    rw_rs_d    = rw_rs_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cursor_d = tail_idx - ONE_C;
          if (flush_all) begin
            rem_d = occ;
            nt_d  = tail_idx - occ[IDX_W-1:0];
          end else begin
            // Entries strictly younger than the branch; modulo DEPTH
            rem_d = {1'b0, tail_idx - br_idx - ONE_C};
            nt_d  = br_idx + ONE_C;
          end
          if (rem_d == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WALK;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WALK: begin
        if (load_s) begin
          if (rem_q == '0) begin
            // Final batch has been accepted: empty the register and report
            rw_valid_d = '0;
            state_d    = ST_DONE;
          end else begin
            // Only valid lanes take new payloads; the rest keep their values
            for (int k = 0; k < WIDTH; k++) begin
              if ((IDX_W+1)'(k) < rem_q) begin
                rw_valid_d[k] = 1'b1;
                rw_arc_d[k]   = rd_arc_dst[k];
                rw_phy_d[k]   = rd_phy_dst[k];
                rw_old_d[k]   = rd_phy_dst_old[k];
                rw_rs_d[k]    = rd_rs_idx[k];
              end else begin
                rw_valid_d[k] = 1'b0;
              end
            end
            cursor_d = cursor_q - take_s[IDX_W-1:0];
            rem_d    = rem_q - take_s;
          end
        end else begin
          // Consumer stalled: hold the current batch unchanged
          state_d = ST_WALK;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        rw_valid_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      new_tail_d = nt_d;
    end else begin
      new_tail_d = '0;
    end
  end

  // State, walk bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cursor_q   <= '0;
      rem_q      <= '0;
      nt_q       <= '0;
      rw_valid_q <= '0;
      rw_arc_q   <= '0;
      rw_phy_q   <= '0;
      rw_old_q   <= '0;
      rw_rs_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      new_tail_q <= '0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      rem_q      <= rem_d;
      nt_q       <= nt_d;
      rw_valid_q <= rw_valid_d;
      rw_arc_q   <= rw_arc_d;
      rw_phy_q   <= rw_phy_d;
      rw_old_q   <= rw_old_d;
      rw_rs_q    <= rw_rs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      new_tail_q <= new_tail_d;
    end
  end

  assign rw_valid       = rw_valid_q;
  assign rw_arc_dst     = rw_arc_q;
  assign rw_phy_dst     = rw_phy_q;
  assign rw_phy_dst_old = rw_old_q;
  assign rw_rs_idx      = rw_rs_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign new_tail       = new_tail_q;

endmodule

// File: tb/tb_rewind_walker.sv
// Self-checking bench for rewind_walker: directed scenarios plus randomized
// walks, checked against a list-of-entries reference model.

module tb_rewind_walker;

  localparam int W  = 3;
  localparam int D  = 32;
  localparam int IW = 5;
  localparam int AW = 5;
  localparam int PW = 7;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic flush_all = 1'b0;
  logic rw_ready = 1'b0;
  logic [IW-1:0] tail_idx = '0;
  logic [IW-1:0] br_idx = '0;
  logic [IW:0]   occ = '0;

  logic [W-1:0][IW-1:0] rd_idx;
  logic [W-1:0][AW-1:0] rd_arc_dst;
  logic [W-1:0][PW-1:0] rd_phy_dst;
  logic [W-1:0][PW-1:0] rd_phy_dst_old;
  logic [W-1:0][RW-1:0] rd_rs_idx;
  logic [W-1:0]         rw_valid;
  logic [W-1:0][AW-1:0] rw_arc_dst;
  logic [W-1:0][PW-1:0] rw_phy_dst;
  logic [W-1:0][PW-1:0] rw_phy_dst_old;
  logic [W-1:0][RW-1:0] rw_rs_idx;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        new_tail;

  logic [AW-1:0] rob_arc [D];
  logic [PW-1:0] rob_phy [D];
  logic [PW-1:0] rob_old [D];
  logic [RW-1:0] rob_rs  [D];

  int n_checks = 0;
  int n_fail = 0;

  rewind_walker #(.WIDTH(W), .DEPTH(D), .IDX_W(IW), .ARC_W(AW), .PHY_W(PW), .RS_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush_all(flush_all),
    .tail_idx(tail_idx), .br_idx(br_idx), .occ(occ), .rd_idx(rd_idx),
    .rd_arc_dst(rd_arc_dst), .rd_phy_dst(rd_phy_dst),
    .rd_phy_dst_old(rd_phy_dst_old), .rd_rs_idx(rd_rs_idx),
    .rw_valid(rw_valid), .rw_arc_dst(rw_arc_dst), .rw_phy_dst(rw_phy_dst),
    .rw_phy_dst_old(rw_phy_dst_old), .rw_rs_idx(rw_rs_idx),
    .rw_ready(rw_ready), .busy(busy), .done(done), .new_tail(new_tail)
  );

  always #5 clk = ~clk;

  // Combinational ROB read port
  always_comb begin
    for (int k = 0; k < W; k++) begin
      rd_arc_dst[k]     = rob_arc[rd_idx[k]];
      rd_phy_dst[k]     = rob_phy[rd_idx[k]];
      rd_phy_dst_old[k] = rob_old[rd_idx[k]];
      rd_rs_idx[k]      = rob_rs[rd_idx[k]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rob();
    for (int i = 0; i < D; i++) begin
      rob_arc[i] = AW'($urandom);
      rob_phy[i] = PW'($urandom);
      rob_old[i] = PW'($urandom);
      rob_rs[i]  = RW'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(rw_valid), 64'd0);
    check({tag, "_arc"}, 64'(rw_arc_dst), 64'd0);
    check({tag, "_phy"}, 64'(rw_phy_dst), 64'd0);
    check({tag, "_old"}, 64'(rw_phy_dst_old), 64'd0);
    check({tag, "_rs"}, 64'(rw_rs_idx), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_ntail"}, 64'(new_tail), 64'd0);
  endtask

  // One complete walk; entered and left #1 after a rising edge with the DUT idle.
  task automatic run_walk(input bit fl, input int tl, input int br, input int oc,
                          input int stall_pct, input logic [63:0] stall_mask,
                          input int inj_cyc, input int exp_done);
    int q[$];
    int n, nt, nb, b, cyc, cnt, idx;
    bit fin, rdy, prev_stall;
    logic [W-1:0] m;
    logic [W-1:0][AW-1:0] p_arc;
    logic [W-1:0][PW-1:0] p_phy;
    logic [W-1:0][PW-1:0] p_old;
    logic [W-1:0][RW-1:0] p_rs;
    string s;

    fill_rob();
    n  = fl ? oc : ((tl - br - 1 + 2*D) % D);
    nt = fl ? ((tl - oc + 2*D) % D) : ((br + 1) % D);
    for (int i = 0; i < n; i++) q.push_back((tl - 1 - i + 2*D) % D);
    nb = (n + W - 1) / W;

    start = 1'b1;
    flush_all = fl;
    tail_idx = tl[IW-1:0];
    br_idx = br[IW-1:0];
    occ = oc[IW:0];
    rw_ready = 1'b1;
    tick();
    start = 1'b0;
    // Inputs other than start are only meaningful at the start cycle
    tail_idx = IW'($urandom);
    br_idx = IW'($urandom);
    occ = (IW+1)'($urandom_range(D));
    flush_all = 1'($urandom);

    cyc = 1; b = 0; fin = 1'b0; prev_stall = 1'b0;
    p_arc = '0; p_phy = '0; p_old = '0; p_rs = '0;
    while (!fin && cyc < 400) begin
      s = $sformatf("c%0d", cyc);
      check({s, "_busy"}, 64'(busy), 64'd1);
      if (b < nb && cyc >= 2) begin
        cnt = (n - b*W < W) ? (n - b*W) : W;
        m = W'((1 << cnt) - 1);
        check({s, "_valid"}, 64'(rw_valid), 64'(m));
        for (int k = 0; k < cnt; k++) begin
          idx = q[b*W + k];
          check($sformatf("%s_l%0d_arc", s, k), 64'(rw_arc_dst[k]), 64'(rob_arc[idx]));
          check($sformatf("%s_l%0d_phy", s, k), 64'(rw_phy_dst[k]), 64'(rob_phy[idx]));
          check($sformatf("%s_l%0d_old", s, k), 64'(rw_phy_dst_old[k]), 64'(rob_old[idx]));
          check($sformatf("%s_l%0d_rs", s, k), 64'(rw_rs_idx[k]), 64'(rob_rs[idx]));
        end
        if (prev_stall) begin
          check({s, "_hold_arc"}, 64'(rw_arc_dst), 64'(p_arc));
          check({s, "_hold_phy"}, 64'(rw_phy_dst), 64'(p_phy));
          check({s, "_hold_old"}, 64'(rw_phy_dst_old), 64'(p_old));
          check({s, "_hold_rs"}, 64'(rw_rs_idx), 64'(p_rs));
        end
        check({s, "_done"}, 64'(done), 64'd0);
      end else if (b < nb) begin
        check({s, "_valid"}, 64'(rw_valid), 64'd0);
        check({s, "_done"}, 64'(done), 64'd0);
      end else begin
        check({s, "_done"}, 64'(done), 64'd1);
        check({s, "_ntail"}, 64'(new_tail), 64'(nt));
        check({s, "_valid"}, 64'(rw_valid), 64'd0);
        if (exp_done >= 0) check("done_cycle", 64'(cyc), 64'(exp_done));
        fin = 1'b1;
      end

      rdy = ($urandom_range(99) >= stall_pct);
      if (cyc < 64 && stall_mask[cyc]) rdy = 1'b0;
      rw_ready = rdy;
      if (cyc == inj_cyc) begin
        start = 1'b1;
        tail_idx = IW'(tl + 7);
        br_idx = IW'($urandom);
        occ = (IW+1)'($urandom_range(D));
        flush_all = 1'($urandom);
      end
      prev_stall = (cyc >= 2) && (b < nb) && !rdy;
      p_arc = rw_arc_dst; p_phy = rw_phy_dst; p_old = rw_phy_dst_old; p_rs = rw_rs_idx;
      if (cyc >= 2 && b < nb && rdy) b++;
      tick();
      start = 1'b0;
      cyc++;
    end
    if (!fin) check("walk_timeout", 64'd0, 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_valid", 64'(rw_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_rob();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Branch rollback wrapping through index 0
    run_walk(1'b0, 5, 29, 0, 0, 64'd0, -1, 5);
    // Full flush with tail == head
    run_walk(1'b1, 10, 0, 32, 0, 64'd0, -1, 13);
    // Backpressure in cycles 2 and 3
    run_walk(1'b0, 5, 29, 0, 0, 64'hC, -1, 7);
    // Nothing to rewind
    run_walk(1'b0, 8, 7, 0, 0, 64'd0, -1, 1);
    // Start while busy is ignored
    run_walk(1'b0, 5, 29, 0, 0, 64'd0, 3, 5);

    // Reset in the middle of a walk
    fill_rob();
    start = 1'b1; flush_all = 1'b0; tail_idx = 5'd5; br_idx = 5'd29; rw_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    check_all_zero("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_walk(1'b0, 5, 29, 0, 0, 64'd0, -1, 5);

    // Randomized walks with random backpressure and ignored restarts
    for (int it = 0; it < 40; it++) begin
      run_walk(1'($urandom_range(3) == 0), $urandom_range(D-1), $urandom_range(D-1),
               $urandom_range(D), 30, 64'd0, $urandom_range(1, 8), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
